// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster constants and helpers
package vga_timing_pkg;

    localparam int POS_W        = 10;

    localparam int H_ACTIVE     = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int V_ACTIVE     = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int BLINK_FRAMES = 30;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrap counter, terminal count, sync window
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [POS_W-1:0] pos,
    output logic             tc,
    output logic             active_next,
    output logic             sync_n
);

    // One extra bit so a window edge equal to 1024 still compares correctly.
    localparam logic [POS_W-1:0] LAST = POS_W'(TOTAL - 1);
    localparam logic [POS_W:0]   ACT  = (POS_W + 1)'(ACTIVE);
    localparam logic [POS_W:0]   SS   = (POS_W + 1)'(SYNC_START);
    localparam logic [POS_W:0]   SE   = (POS_W + 1)'(SYNC_END);

    logic [POS_W-1:0] next_pos;
    logic [POS_W:0]   next_ext;
    logic             sync_next_n;

    // Next position and the flags it implies, so flags register alongside pos.
    always_comb begin
        tc       = (pos == LAST);
        next_pos = pos;
        if (step) begin
            next_pos = tc ? '0 : pos + 1'b1;
        end
        next_ext    = {1'b0, next_pos};
        active_next = (next_ext < ACT);
        sync_next_n = !((next_ext >= SS) && (next_ext < SE));
    end

    // Reset parks the axis on its last position so the first step lands on 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos    <= LAST;
            sync_n <= 1'b1;
        end else begin
            pos    <= next_pos;
            sync_n <= sync_next_n;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator; VGA_TIMING_BLINK_EN enables cursor blink
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE_P     = H_ACTIVE,
    parameter int H_FP_P         = H_FP,
    parameter int H_SYNC_P       = H_SYNC,
    parameter int H_BP_P         = H_BP,
    parameter int V_ACTIVE_P     = V_ACTIVE,
    parameter int V_FP_P         = V_FP,
    parameter int V_SYNC_P       = V_SYNC,
    parameter int V_BP_P         = V_BP,
    parameter int BLINK_FRAMES_P = BLINK_FRAMES
) (
    input  logic             disp_clock,
    input  logic             reset,
    input  logic             en,
    output logic [POS_W-1:0] h_pos,
    output logic [POS_W-1:0] v_pos,
    output logic             valid_draw,
    output logic             v_blank,
    output logic             h_sync,
    output logic             v_sync,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count,
    output logic             blink
);

    localparam int HT = axis_total(H_ACTIVE_P, H_FP_P, H_SYNC_P, H_BP_P);
    localparam int VT = axis_total(V_ACTIVE_P, V_FP_P, V_SYNC_P, V_BP_P);

    if (HT > 1024) begin : g_h_too_big
        $error("vga_timing_gen: horizontal total exceeds 1024");
    end
    if (VT > 1024) begin : g_v_too_big
        $error("vga_timing_gen: vertical total exceeds 1024");
    end
    if (BLINK_FRAMES_P < 1) begin : g_blink_bad
        $error("vga_timing_gen: blink period must be at least one frame");
    end

    logic h_tc, v_tc, h_act_next, v_act_next, v_step;
    logic armed;

    assign v_step = en & h_tc;

    vga_axis_counter #(
        .TOTAL      (HT),
        .ACTIVE     (H_ACTIVE_P),
        .SYNC_START (H_ACTIVE_P + H_FP_P),
        .SYNC_END   (H_ACTIVE_P + H_FP_P + H_SYNC_P)
    ) u_h (
        .clk         (disp_clock),
        .reset       (reset),
        .step        (en),
        .pos         (h_pos),
        .tc          (h_tc),
        .active_next (h_act_next),
        .sync_n      (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (VT),
        .ACTIVE     (V_ACTIVE_P),
        .SYNC_START (V_ACTIVE_P + V_FP_P),
        .SYNC_END   (V_ACTIVE_P + V_FP_P + V_SYNC_P)
    ) u_v (
        .clk         (disp_clock),
        .reset       (reset),
        .step        (v_step),
        .pos         (v_pos),
        .tc          (v_tc),
        .active_next (v_act_next),
        .sync_n      (v_sync)
    );

    // Flags, markers and frame counter, registered from the same next position as the axes.
    // armed marks the wrap out of the reset position, which is not a completed frame.
    always_ff @(posedge disp_clock) begin
        if (reset) begin
            valid_draw  <= 1'b0;
            v_blank     <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
            armed       <= 1'b1;
        end else begin
            line_start  <= en & h_tc;
            frame_start <= en & h_tc & v_tc;
            if (en) begin
                valid_draw <= h_act_next & v_act_next;
                v_blank    <= ~v_act_next;
                armed      <= 1'b0;
                if (h_tc && v_tc && !armed) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

`ifdef VGA_TIMING_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES_P + 1);
    logic [BW-1:0] blink_cnt;

    // Toggle blink after every BLINK_FRAMES_P completed frames, on the frame_start cycle.
    always_ff @(posedge disp_clock) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (en && h_tc && v_tc && !armed) begin
            if (blink_cnt == BW'(BLINK_FRAMES_P - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign blink = 1'b0;
`endif

endmodule
